// File: rtl/riscv_mul_pkg.sv
// Shared types and configuration limits for the pipelined M-extension multiplier.
package riscv_mul_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   localparam int XLEN_MIN   = 32;
   localparam int XLEN_MAX   = 64;
   localparam int STAGES_MAX = 4;
   localparam int TAG_W_MAX  = 16;
   localparam int PROD_W_MAX = 2 * XLEN_MAX;

   // Slot 0 keeps {a, b} in the product field; later slots keep the low 2*XLEN product bits.
   typedef struct packed {
      logic                  valid;
      mul_op_e               op;
      logic [TAG_W_MAX-1:0]  tag;
      logic [PROD_W_MAX-1:0] product;
   } mul_slot_t;

endpackage

// File: rtl/riscv_mul_core.sv
// Combinational (XLEN+1)-bit signed multiply and op-based result select from a product.
module riscv_mul_core
   import riscv_mul_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  mul_op_e           op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [2*XLEN-1:0] product,
   input  mul_op_e           sel_op,
   input  logic [2*XLEN-1:0] sel_product,
   output logic [XLEN-1:0]   result
);

   logic              a_sx;
   logic              b_sx;
   logic [2*XLEN+1:0] a_ext;
   logic [2*XLEN+1:0] b_ext;
   logic [2*XLEN+1:0] full;
   logic              unused_full_top;

   // Sign-extending to the full product width lets a plain modular multiply give the signed result.
   always_comb begin
      a_sx    = (op == MULH) || (op == MULHSU);
      b_sx    = (op == MULH);
      a_ext   = {{(XLEN+2){a_sx & a[XLEN-1]}}, a};
      b_ext   = {{(XLEN+2){b_sx & b[XLEN-1]}}, b};
      full    = a_ext * b_ext;
      product = full[2*XLEN-1:0];
   end

   assign unused_full_top = ^full[2*XLEN+1:2*XLEN];

   assign result = (sel_op == MUL) ? sel_product[XLEN-1:0] : sel_product[2*XLEN-1:XLEN];

endmodule

// File: rtl/riscv_mul_pipe.sv
// Pipelined RISC-V MUL/MULH/MULHSU/MULHU unit with valid/ready, tag and flush.
// Define RISCV_MUL_FUSE_EN to add the last-result cache with idle bypass to the output slot.
module riscv_mul_pipe
   import riscv_mul_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       in_op_i,
   input  logic [XLEN-1:0]  in_a_i,
   input  logic [XLEN-1:0]  in_b_i,
   input  logic [TAG_W-1:0] in_tag_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  out_result_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic             busy_o
);

   localparam int LAST = STAGES - 1;
   localparam int PW   = 2 * XLEN;

   if ((XLEN != XLEN_MIN && XLEN != XLEN_MAX) || STAGES < 1 || STAGES > STAGES_MAX ||
       TAG_W < 1 || TAG_W > TAG_W_MAX) begin : g_bad_cfg
      $error("riscv_mul_pipe: unsupported XLEN/STAGES/TAG_W");
   end

   mul_slot_t       slot_q  [STAGES];
   mul_slot_t       shift_d [STAGES];
   mul_slot_t       slot_d  [STAGES];
   logic            advance;
   logic            accept;
   logic            busy;
   mul_op_e         req_op;
   mul_op_e         core_op;
   logic [XLEN-1:0] core_a;
   logic [XLEN-1:0] core_b;
   logic [PW-1:0]   core_prod;
   logic            unused_slot_bits;

   assign req_op     = mul_op_e'(in_op_i);
   assign advance    = !slot_q[LAST].valid | out_ready_i;
   assign accept     = in_valid_i & advance & !flush_i;
   assign in_ready_o = advance;

   if (STAGES == 1) begin : g_single
      assign core_op = req_op;
      assign core_a  = in_a_i;
      assign core_b  = in_b_i;
      always_comb begin
         shift_d[0] = '{valid: accept, op: req_op, tag: TAG_W_MAX'(in_tag_i),
                        product: PROD_W_MAX'(core_prod)};
      end
   end else begin : g_multi
      assign core_op = slot_q[0].op;
      assign core_a  = slot_q[0].product[PW-1:XLEN];
      assign core_b  = slot_q[0].product[XLEN-1:0];
      always_comb begin
         shift_d[0] = '{valid: accept, op: req_op, tag: TAG_W_MAX'(in_tag_i),
                        product: PROD_W_MAX'({in_a_i, in_b_i})};
         shift_d[1] = '{valid: slot_q[0].valid, op: slot_q[0].op, tag: slot_q[0].tag,
                        product: PROD_W_MAX'(core_prod)};
         for (int k = 2; k < STAGES; k++) shift_d[k] = slot_q[k-1];
      end
   end

   riscv_mul_core #(.XLEN(XLEN)) u_core (
      .op          (core_op),
      .a           (core_a),
      .b           (core_b),
      .product     (core_prod),
      .sel_op      (slot_q[LAST].op),
      .sel_product (slot_q[LAST].product[PW-1:0]),
      .result      (out_result_o)
   );

`ifdef RISCV_MUL_FUSE_EN
   logic [XLEN-1:0] opa_q [STAGES];
   logic [XLEN-1:0] opb_q [STAGES];
   logic            cache_valid;
   mul_op_e         cache_op;
   logic [XLEN-1:0] cache_a;
   logic [XLEN-1:0] cache_b;
   logic [PW-1:0]   cache_prod;
   logic            hit;
   logic            bypass;

   // MUL takes the low half, which is identical for every signedness class.
   assign hit = cache_valid && (in_a_i == cache_a) && (in_b_i == cache_b) &&
                (req_op == MUL || req_op == cache_op);
   assign bypass = accept & hit & !busy;

   always_comb begin
      slot_d = shift_d;
      if (bypass) begin
         slot_d[0].valid = 1'b0;
         slot_d[LAST]    = '{valid: 1'b1, op: req_op, tag: TAG_W_MAX'(in_tag_i),
                             product: PROD_W_MAX'(cache_prod)};
      end
   end

   // Operands ride alongside the slots so the cache can capture them when a result pops.
   always_ff @(posedge clk_i) begin
      if (advance) begin
         opa_q[0] <= in_a_i;
         opb_q[0] <= in_b_i;
         for (int k = 1; k < STAGES; k++) begin
            opa_q[k] <= opa_q[k-1];
            opb_q[k] <= opb_q[k-1];
         end
         if (bypass) begin
            opa_q[LAST] <= in_a_i;
            opb_q[LAST] <= in_b_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cache_valid <= 1'b0;
         cache_op    <= MUL;
         cache_a     <= '0;
         cache_b     <= '0;
         cache_prod  <= '0;
      end else if (flush_i) begin
         cache_valid <= 1'b0;
      end else if (slot_q[LAST].valid && out_ready_i) begin
         cache_valid <= 1'b1;
         cache_op    <= slot_q[LAST].op;
         cache_a     <= opa_q[LAST];
         cache_b     <= opb_q[LAST];
         cache_prod  <= slot_q[LAST].product[PW-1:0];
      end
   end
`else
   always_comb slot_d = shift_d;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < STAGES; k++) slot_q[k] <= '0;
      end else if (flush_i) begin
         for (int k = 0; k < STAGES; k++) slot_q[k].valid <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) slot_q[k] <= slot_d[k];
      end
   end

   always_comb begin
      busy             = 1'b0;
      unused_slot_bits = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         busy             = busy | slot_q[k].valid;
         unused_slot_bits = unused_slot_bits ^ (^slot_q[k]);
      end
   end

   assign busy_o      = busy;
   assign out_valid_o = slot_q[LAST].valid;
   assign out_tag_o   = slot_q[LAST].tag[TAG_W-1:0];

endmodule

// File: tb/tb_riscv_mul_pipe.sv
// Directed bench: 32-bit/2-stage, 32-bit/4-stage and 64-bit/2-stage instances of riscv_mul_pipe.
module tb_riscv_mul_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, flush, out_ready;
   logic [1:0]  in_op;
   logic [31:0] in_a, in_b;
   logic [4:0]  in_tag;

   logic        rdy32, ov32, busy32;
   logic [31:0] res32;
   logic [4:0]  tag32;
   logic        rdy4, ov4, busy4;
   logic [31:0] res4;
   logic [4:0]  tag4;

   logic        v64, flush64, ordy64;
   logic [1:0]  op64;
   logic [63:0] a64, b64;
   logic [4:0]  itag64;
   logic        rdy64, ov64, busy64;
   logic [63:0] res64;
   logic [4:0]  otag64;

   int          n_chk = 0;
   int          n_fail = 0;
   int          sent, rcv, cyc;
   logic        hold;
   logic [31:0] hres;
   logic [4:0]  htag;
   logic [31:0] exp_tab [8];

   riscv_mul_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_dut32 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy32),
      .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag), .flush_i(flush),
      .out_valid_o(ov32), .out_ready_i(out_ready), .out_result_o(res32),
      .out_tag_o(tag32), .busy_o(busy32));

   riscv_mul_pipe #(.XLEN(32), .STAGES(4), .TAG_W(5)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy4),
      .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag), .flush_i(flush),
      .out_valid_o(ov4), .out_ready_i(out_ready), .out_result_o(res4),
      .out_tag_o(tag4), .busy_o(busy4));

   riscv_mul_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) u_dut64 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v64), .in_ready_o(rdy64),
      .in_op_i(op64), .in_a_i(a64), .in_b_i(b64), .in_tag_i(itag64), .flush_i(flush64),
      .out_valid_o(ov64), .out_ready_i(ordy64), .out_result_o(res64),
      .out_tag_o(otag64), .busy_o(busy64));

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({name, "_early"}, 64'(ov32), 64'd0);
      tick();
      chk({name, "_valid"}, 64'(ov32), 64'd1);
      chk({name, "_res"}, 64'(res32), 64'(exp));
      chk({name, "_tag"}, 64'(tag32), 64'(tag));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_tab = '{32'd3, 32'd8, 32'd15, 32'd24, 32'd35, 32'd48, 32'd63, 32'd80};
      in_valid = 0; flush = 0; out_ready = 1; in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
      v64 = 0; flush64 = 0; ordy64 = 1; op64 = 0; a64 = 0; b64 = 0; itag64 = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(ov32), 64'd0);
      chk("rst_res", 64'(res32), 64'd0);
      chk("rst_tag", 64'(tag32), 64'd0);
      chk("rst_busy", 64'(busy32), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("rst_ready", 64'(rdy32), 64'd1);
      tick();

      // 64-bit: MULH first, then MUL on the same operands while idle
      v64 = 1; op64 = 2'b01; a64 = 64'h8000_0000_0000_0001; b64 = 64'h2; itag64 = 5'd3;
      tick();
      v64 = 0;
      chk("x64_mulh_early", 64'(ov64), 64'd0);
      tick();
      chk("x64_mulh_valid", 64'(ov64), 64'd1);
      chk("x64_mulh_res", res64, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("x64_mulh_tag", 64'(otag64), 64'd3);
      tick();
      chk("x64_idle", 64'(busy64), 64'd0);
      v64 = 1; op64 = 2'b00; itag64 = 5'd4;
      tick();
      v64 = 0;
`ifdef RISCV_MUL_FUSE_EN
      chk("x64_mul_fast_valid", 64'(ov64), 64'd1);
`else
      chk("x64_mul_early", 64'(ov64), 64'd0);
      tick();
      chk("x64_mul_valid", 64'(ov64), 64'd1);
`endif
      chk("x64_mul_res", res64, 64'h2);
      chk("x64_mul_tag", 64'(otag64), 64'd4);
      tick();

      run_op("mul",    2'b00, 32'h8000_0001, 32'h0001_0002, 5'd1, 32'h0001_0002);
      run_op("mulhu",  2'b11, 32'h8000_0001, 32'h0001_0002, 5'd2, 32'h0000_8001);
      run_op("mulh",   2'b01, 32'h8000_0001, 32'h0001_0002, 5'd3, 32'hFFFF_7FFF);
      run_op("mulh_mm", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
      run_op("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF);
      run_op("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
      run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001);

      // burst of 8 tagged MULs with the consumer ready every other cycle
      sent = 0; rcv = 0; cyc = 0; hold = 1'b0; hres = '0; htag = '0;
      while (rcv < 8 && cyc < 100) begin
         if (hold) begin
            chk("stall_valid", 64'(ov32), 64'd1);
            chk("stall_res", 64'(res32), 64'(hres));
            chk("stall_tag", 64'(tag32), 64'(htag));
         end
         out_ready = (cyc % 2) == 1;
         in_valid  = sent < 8;
         in_op     = 2'b00;
         in_a      = 32'(sent + 1);
         in_b      = 32'(sent + 3);
         in_tag    = 5'(sent);
         #1;
         hold = ov32 & !out_ready;
         if (hold) begin
            hres = res32;
            htag = tag32;
            chk("stall_ready", 64'(rdy32), 64'd0);
         end
         if (ov32 && out_ready) begin
            chk("burst_res", 64'(res32), 64'(exp_tab[rcv]));
            chk("burst_tag", 64'(tag32), 64'(rcv));
            rcv++;
         end
         if (in_valid && rdy32) sent++;
         cyc++;
         tick();
      end
      chk("burst_count", 64'(rcv), 64'd8);
      in_valid = 0; out_ready = 1;
      tick();
      chk("burst_idle", 64'(busy32), 64'd0);

      // asynchronous reset with a result sitting in the output slot
      in_valid = 1; in_op = 2'b11; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_tag = 5'h1F;
      out_ready = 0;
      tick();
      in_valid = 0;
      tick();
      chk("prerst_valid", 64'(ov32), 64'd1);
      chk("prerst_res", 64'(res32), 64'hFFFF_FFFE);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(ov32), 64'd0);
      chk("midrst_res", 64'(res32), 64'd0);
      chk("midrst_tag", 64'(tag32), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("postrst_ready", 64'(rdy32), 64'd1);
      chk("postrst_busy", 64'(busy32), 64'd0);
      out_ready = 1;
      tick();

      // 4-stage: three in flight, then flush with a fourth request in the same cycle
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_op = 2'b00; in_a = 32'(i + 2); in_b = 32'd7; in_tag = 5'(i);
         tick();
         chk("flush_pre_valid", 64'(ov4), 64'd0);
      end
      in_valid = 1; in_a = 32'd9; in_tag = 5'd3; flush = 1;
      #1 chk("flush_ready", 64'(rdy4), 64'd1);
      tick();
      flush = 0; in_valid = 0;
      chk("flush_busy", 64'(busy4), 64'd0);
      chk("flush_valid", 64'(ov4), 64'd0);
      repeat (4) begin
         tick();
         chk("flush_after_valid", 64'(ov4), 64'd0);
      end

      // 4-stage latency
      in_valid = 1; in_op = 2'b00; in_a = 32'd3; in_b = 32'd5; in_tag = 5'd9;
      tick();
      in_valid = 0;
      repeat (3) begin
         chk("lat4_early", 64'(ov4), 64'd0);
         tick();
      end
      chk("lat4_valid", 64'(ov4), 64'd1);
      chk("lat4_res", 64'(res4), 64'd15);
      chk("lat4_tag", 64'(tag4), 64'd9);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_mul_pipe.md
# riscv_mul_pipe

Parametrised, pipelined RISC-V M-extension multiplier: next generation of the single-width multiplier in the integer execute path. Supports MUL, MULH, MULHSU and MULHU at XLEN 32 or 64. Pipeline depth is configurable. Uses valid/ready handshakes on both sides, carries a destination tag, and supports a flush for branch mispredict and trap. Sits beside the ALU; results go to the writeback arbiter.

## Interface
- XLEN, 32: operand/result width; legal values 32, 64.
- STAGES, 2: cycles from accept to result valid; legal 1..4.
- TAG_W, 5: width of the opaque tag carried with each operation (rd index).

- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i & in_ready_o.
- in_op_i  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_a_i  in  XLEN  rs1 operand.
- in_b_i  in  XLEN  rs2 operand.
- in_tag_i  in  TAG_W  tag, returned unchanged.
- flush_i  in  1  discard all in-flight and same-cycle requests.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- out_result_o  out  XLEN  result.
- out_tag_o  out  TAG_W  tag of result.
- busy_o  out  1  any stage valid, including the output stage.

## Operation
- Operand extension to XLEN+1 bits:
  - a is sign-extended for MULH and MULHSU, otherwise zero-extended.
  - b is sign-extended for MULH only, otherwise zero-extended.
- Product: (XLEN+1)×(XLEN+1) signed multiply, giving a 2·XLEN+2-bit result.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2·XLEN-1:XLEN].
- Pipeline: STAGES register slots, each holding a valid bit, op, tag and partial/full product.
  - Slot 0 captures the request; the last slot drives the out_* ports.
  - Multiply logic is placed between slot 0 and slot 1.
  - With STAGES=1, the multiply is combinational into the single output slot.
- Advance condition: advance = !out_valid_o | out_ready_i. All slots shift together when advance is true; otherwise all hold.
- in_ready_o = advance, which is combinational from out_ready_i. There is no skid buffer.
- Results leave strictly in accept order. Bubbles are not compressed.
- Flush: a flush_i high on an edge clears every valid bit, including the output slot.
  - A request presented in the same cycle as flush_i is dropped, even if in_ready_o is 1.
  - in_ready_o is not gated by flush_i.
- Reset: all valid bits 0, out_result_o 0, out_tag_o 0, busy_o 0.
  - in_ready_o is 1 once reset is released.
  - Non-output data registers need no reset.
  - Asserting reset mid-operation drops everything in flight.

## Timing
- Latency: a request accepted at edge N gives out_valid_o=1 after edge N+STAGES-1, provided there are no output stalls.
- Throughput: one request per cycle while out_ready_i=1.
- Stall: while out_valid_o & !out_ready_i:
  - out_result_o and out_tag_o are stable;
  - in_ready_o=0;
  - no slot changes.
- Simultaneous accept and output pop on the same edge is legal and is the steady state.
- The output is registered; out_ready_i has no combinational path to out_*.

## Configuration
- RISCV_MUL_FUSE_EN defined:
  - A cache holds the a, b, signedness class and full product of the last result that left the output slot. The cache is invalidated by reset and by flush_i.
  - A request hits the cache when a and b match and either the op is MUL or the op equals the cached op.
  - A hit accepted while busy_o=0 loads the output slot directly, giving out_valid_o one edge after acceptance.
  - Hits while busy_o=1 use the normal pipeline, so ordering is preserved.
- RISCV_MUL_FUSE_EN undefined: no cache and no bypass; latency is always STAGES.

## Structure
- Package riscv_mul_pkg holds:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU);
  - the XLEN legality check constants;
  - the slot struct type (valid, op, tag, product).
- Sub-module riscv_mul_core: purely combinational (XLEN+1)-bit signed multiplier plus op-based result select. It is instantiated once between slot 0 and slot 1.

## Test plan
- XLEN=32, STAGES=2, MUL a=0x80000001 b=0x00010002 -> result 0x00010002 two cycles after accept; MULHU on the same operands -> 0x00008001; MULH -> 0xFFFF7FFF.
- MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU on the same operands -> 0xFFFFFFFE.
- Back-to-back burst of 8 tagged requests with out_ready_i toggling every other cycle -> all 8 results in order, tags 0..7, none lost or duplicated, outputs stable while stalled.
- Three requests in flight, then flush_i plus a new request in the same cycle -> no out_valid_o for any of the four; busy_o=0 next cycle.
- rst_ni low mid-burst -> out_valid_o, out_result_o and out_tag_o all 0 asynchronously; after release in_ready_o=1.
- RISCV_MUL_FUSE_EN, XLEN=64: MULH a=0x8000000000000001 b=0x2 -> result 0xFFFFFFFFFFFFFFFF after 2 cycles; then MUL on the same operands while idle -> 0x0000000000000002 after 1 cycle.
